// File: rtl/bep_pkg.sv
// bep_pkg: shared definitions for the BEP thermostat frame encoder.
//   - FRAME_BITS and the field widths of the 192-bit frame
//   - host byte-address map (ADDR_ID0..ADDR_TAIL3), same map as the decoder
//   - FSM state encoding (IDLE/SHIFT/GAP)
//   - default fixed-field values (PREAMBLE/TYPE_1/TYPE_2/CONSTANT)
//   - frame_t: packed frame layout; the first member is the first bit sent
package bep_pkg;

  localparam int FRAME_BITS    = 192;
  localparam int PREAMBLE_W    = 32;
  localparam int TYPE_W        = 16;
  localparam int CONSTANT_W    = 32;
  localparam int ID_W          = 32;
  localparam int TEMP_W        = 16;
  localparam int BYTE_W        = 8;

  localparam logic [3:0] ADDR_ID0   = 4'd0;
  localparam logic [3:0] ADDR_ID1   = 4'd1;
  localparam logic [3:0] ADDR_ID2   = 4'd2;
  localparam logic [3:0] ADDR_ID3   = 4'd3;
  localparam logic [3:0] ADDR_ROOM0 = 4'd4;
  localparam logic [3:0] ADDR_ROOM1 = 4'd5;
  localparam logic [3:0] ADDR_SET0  = 4'd6;
  localparam logic [3:0] ADDR_SET1  = 4'd7;
  localparam logic [3:0] ADDR_STATE = 4'd8;
  localparam logic [3:0] ADDR_TAIL1 = 4'd9;
  localparam logic [3:0] ADDR_TAIL2 = 4'd10;
  localparam logic [3:0] ADDR_TAIL3 = 4'd11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [PREAMBLE_W-1:0] DEF_PREAMBLE = 32'hAAAA_AAAA;
  localparam logic [TYPE_W-1:0]     DEF_TYPE_1   = 16'h0000;
  localparam logic [TYPE_W-1:0]     DEF_TYPE_2   = 16'h0000;
  localparam logic [CONSTANT_W-1:0] DEF_CONSTANT = 32'h0000_0000;

  typedef struct packed {
    logic [PREAMBLE_W-1:0] preamble;
    logic [TYPE_W-1:0]     type_1;
    logic [TYPE_W-1:0]     type_2;
    logic [CONSTANT_W-1:0] cnst;
    logic [ID_W-1:0]       thermostat_id;
    logic [TEMP_W-1:0]     room_temp;
    logic [TEMP_W-1:0]     set_temp;
    logic [BYTE_W-1:0]     state;
    logic [BYTE_W-1:0]     tail_1;
    logic [BYTE_W-1:0]     tail_2;
    logic [BYTE_W-1:0]     tail_3;
  } frame_t;

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: bit-clock generator for serial_encode.
// Each bit is CLK_DIV system clocks low followed by CLK_DIV clocks high.
//   clock, reset  system clock, synchronous active-high reset
//   enable        run the timer; when low the timer parks in the low phase
//   serial_clock  generated bit clock (registered)
//   bit_end       strobe on the final high-phase cycle of a bit
//   low_phase     high while serial_clock is low
module serial_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic serial_clock,
  output logic bit_end,
  output logic low_phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;

  // Disabled means restart from the beginning of a low phase, so the
  // first enabled cycle is always low-phase cycle 0.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  assign serial_clock = phase;
  assign low_phase    = ~phase;
  assign bit_end      = enable && phase && (cnt == LAST);

endmodule

// File: rtl/serial_encode.sv
// serial_encode: host-loaded BEP thermostat frame transmitter.
// The host writes field bytes over address/write_data/write_en, then pulses
// start; one 192-bit frame is shifted out MSB first on serial_clock /
// serial_data, followed by GAP_CYCLES idle clocks and a done pulse.
// Optional macro FRAME_REPEAT_EN adds repeat_count: the snapshot is resent
// repeat_count+1 times, with a single done after the last one.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   address[3:0]        field byte select (12-15 ignored)
//   write_data[7:0]     byte to store
//   write_en            store write_data at address
//   start               one-cycle send request (ignored while busy)
//   repeat_count[3:0]   extra repeats (FRAME_REPEAT_EN only)
//   serial_clock        bit clock, idle low
//   serial_data         frame bit, stable across rising serial_clock
//   busy                frame in progress
//   done                one-cycle completion pulse
module serial_encode
  import bep_pkg::*;
#(
  parameter int                      CLK_DIV    = 4,
  parameter int                      GAP_CYCLES = 16,
  parameter logic [PREAMBLE_W-1:0]   PREAMBLE   = DEF_PREAMBLE,
  parameter logic [TYPE_W-1:0]       TYPE_1     = DEF_TYPE_1,
  parameter logic [TYPE_W-1:0]       TYPE_2     = DEF_TYPE_2,
  parameter logic [CONSTANT_W-1:0]   CONSTANT   = DEF_CONSTANT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] address,
  input  logic [7:0] write_data,
  input  logic       write_en,
  input  logic       start,
`ifdef FRAME_REPEAT_EN
  input  logic [3:0] repeat_count,
`endif
  output logic       serial_clock,
  output logic       serial_data,
  output logic       busy,
  output logic       done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    BIT_TOP  = 8'(FRAME_BITS - 1);

  logic [ID_W-1:0]       id_r;
  logic [TEMP_W-1:0]     room_r, set_r;
  logic [BYTE_W-1:0]     state_r, tail1_r, tail2_r, tail3_r;

  logic [1:0]            fsm;
  logic [FRAME_BITS-1:0] shreg;
  logic [7:0]            bit_cnt;
  logic [GW-1:0]         gap_cnt;
  frame_t                frame_now;

`ifdef FRAME_REPEAT_EN
  logic [FRAME_BITS-1:0] snap;
  logic [3:0]            rep_left;
`endif

  logic bit_end, low_phase, adv;

  serial_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clock        (clock),
    .reset        (reset),
    .enable       (fsm == ST_SHIFT),
    .serial_clock (serial_clock),
    .bit_end      (bit_end),
    .low_phase    (low_phase)
  );

  // Advance only out of a high phase so data moves while the clock falls.
  assign adv = bit_end && !low_phase;

  always_comb begin
    frame_now               = '0;
    frame_now.preamble      = PREAMBLE;
    frame_now.type_1        = TYPE_1;
    frame_now.type_2        = TYPE_2;
    frame_now.cnst          = CONSTANT;
    frame_now.thermostat_id = id_r;
    frame_now.room_temp     = room_r;
    frame_now.set_temp      = set_r;
    frame_now.state         = state_r;
    frame_now.tail_1        = tail1_r;
    frame_now.tail_2        = tail2_r;
    frame_now.tail_3        = tail3_r;
  end

  // Shifting in zeros leaves shreg empty after the last bit, which is what
  // holds serial_data low during GAP and IDLE.
  assign serial_data = shreg[FRAME_BITS-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      id_r    <= '0;
      room_r  <= '0;
      set_r   <= '0;
      state_r <= '0;
      tail1_r <= '0;
      tail2_r <= '0;
      tail3_r <= '0;
      fsm     <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef FRAME_REPEAT_EN
      snap     <= '0;
      rep_left <= '0;
`endif
    end else begin
      done <= 1'b0;

      // Field writes land on this edge; a same-cycle start snapshots
      // frame_now, which still holds the old values.
      if (write_en) begin
        case (address)
          ADDR_ID0:   id_r[7:0]     <= write_data;
          ADDR_ID1:   id_r[15:8]    <= write_data;
          ADDR_ID2:   id_r[23:16]   <= write_data;
          ADDR_ID3:   id_r[31:24]   <= write_data;
          ADDR_ROOM0: room_r[7:0]   <= write_data;
          ADDR_ROOM1: room_r[15:8]  <= write_data;
          ADDR_SET0:  set_r[7:0]    <= write_data;
          ADDR_SET1:  set_r[15:8]   <= write_data;
          ADDR_STATE: state_r       <= write_data;
          ADDR_TAIL1: tail1_r       <= write_data;
          ADDR_TAIL2: tail2_r       <= write_data;
          ADDR_TAIL3: tail3_r       <= write_data;
          default: ;
        endcase
      end

      case (fsm)
        ST_IDLE: begin
          if (start) begin
            shreg   <= frame_now;
            bit_cnt <= BIT_TOP;
            busy    <= 1'b1;
            fsm     <= ST_SHIFT;
`ifdef FRAME_REPEAT_EN
            snap     <= frame_now;
            rep_left <= repeat_count;
`endif
          end
        end
        ST_SHIFT: begin
          if (adv) begin
            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt == 8'd0) begin
              gap_cnt <= '0;
              fsm     <= ST_GAP;
            end else begin
              bit_cnt <= bit_cnt - 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
`ifdef FRAME_REPEAT_EN
            if (rep_left != 4'd0) begin
              rep_left <= rep_left - 4'd1;
              shreg    <= snap;
              bit_cnt  <= BIT_TOP;
              fsm      <= ST_SHIFT;
            end else begin
              busy <= 1'b0;
              done <= 1'b1;
              fsm  <= ST_IDLE;
            end
`else
            busy <= 1'b0;
            done <= 1'b1;
            fsm  <= ST_IDLE;
`endif
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_encode.sv
// tb_serial_encode: directed bench for serial_encode. Expected frames are
// pushed to a queue at start; a negedge monitor deserialises rising
// serial_clock edges and pops/compares each completed 192-bit frame.
module tb_serial_encode;

  localparam int CD = 4;
  localparam int G  = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] address = '0;
  logic [7:0] write_data = '0;
  logic       write_en = 1'b0;
  logic       start = 1'b0;
`ifdef FRAME_REPEAT_EN
  logic [3:0] repeat_count = '0;
`endif
  logic       serial_clock, serial_data, busy, done;

  serial_encode #(.CLK_DIV(CD), .GAP_CYCLES(G)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .write_en     (write_en),
    .start        (start),
`ifdef FRAME_REPEAT_EN
    .repeat_count (repeat_count),
`endif
    .serial_clock (serial_clock),
    .serial_data  (serial_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [191:0] expq[$];

  logic [191:0] acc = '0;
  int   bits = 0, rises = 0, first_rise = -1;
  int   done_cnt = 0, done_cyc = -1, busy_cyc = -1;
  logic prev_sclk = 1'b0, prev_busy = 1'b0, prev_sd = 1'b0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [191:0] frame(input logic [31:0] id, input logic [15:0] room,
                                         input logic [15:0] set, input logic [7:0] st,
                                         input logic [7:0] t1, input logic [7:0] t2,
                                         input logic [7:0] t3);
    return {32'hAAAA_AAAA, 16'h0000, 16'h0000, 32'h0000_0000, id, room, set, st, t1, t2, t3};
  endfunction

  // Monitor: serial_data is sampled where serial_clock is seen rising.
  always @(negedge clock) begin
    if (reset) begin
      bits      = 0;
      prev_sclk = 1'b0;
      prev_busy = 1'b0;
      prev_sd   = 1'b0;
    end else begin
      if (serial_clock && !prev_sclk) begin
        acc = {acc[190:0], serial_data};
        bits++;
        rises++;
        if (first_rise < 0) first_rise = cyc;
        if (bits == 192) begin
          bits = 0;
          if (expq.size() == 0) chk("frame_expected", 192'(expq.size()), 192'd1);
          else chk("frame", acc, expq.pop_front());
        end
      end
      if (serial_clock && prev_sclk) chk("sd_stable_high", 192'(serial_data), 192'(prev_sd));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_at_done", 192'(busy), 192'd0);
      end
      if (busy && !prev_busy) busy_cyc = cyc;
      prev_sclk = serial_clock;
      prev_busy = busy;
      prev_sd   = serial_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; write_data = d; write_en = 1'b1;
    tick(1);
    write_en = 1'b0;
  endtask

  task automatic go(output int s);
    s = cyc; rises = 0; first_rise = -1; busy_cyc = -1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin tick(1); n++; end
    tick(1);
    chk("done_within_budget", 192'(done_cnt != d0), 192'd1);
  endtask

  task automatic chk_timing(input int s);
    chk("busy_rise_cycle",  192'(busy_cyc),   192'(s + 1));
    chk("first_rise_cycle", 192'(first_rise), 192'(s + 1 + CD));
    chk("done_cycle",       192'(done_cyc),   192'(s + 1 + 384 * CD + G));
    chk("rise_count",       192'(rises),      192'd192);
  endtask

  initial begin
    int s, d0, n;
    logic [191:0] f1, f2;

    tick(3);
    chk("rst_sclk", 192'(serial_clock), 192'd0);
    chk("rst_sd",   192'(serial_data),  192'd0);
    chk("rst_busy", 192'(busy),         192'd0);
    chk("rst_done", 192'(done),         192'd0);
    reset = 1'b0;
    tick(100);
    chk("idle_sclk",    192'(serial_clock), 192'd0);
    chk("idle_sd",      192'(serial_data),  192'd0);
    chk("idle_busy",    192'(busy),         192'd0);
    chk("idle_no_done", 192'(done_cnt),     192'd0);

    wr(4'd0, 8'h78); wr(4'd1, 8'h56); wr(4'd2, 8'h34); wr(4'd3, 8'h12);
    wr(4'd4, 8'hD2); wr(4'd5, 8'h00); wr(4'd6, 8'hC8); wr(4'd7, 8'h00);
    wr(4'd8, 8'h01); wr(4'd9, 8'hA1); wr(4'd10, 8'hA2); wr(4'd11, 8'hA3);
    wr(4'd12, 8'hEE); wr(4'd15, 8'h77);   // unmapped, must not land anywhere
    f1 = frame(32'h1234_5678, 16'h00D2, 16'h00C8, 8'h01, 8'hA1, 8'hA2, 8'hA3);

    tick(5);
    expq.push_back(f1);
    go(s);
    wait_done(4000);
    chk_timing(s);
    chk("q_empty_1", 192'(expq.size()), 192'd0);
    chk("done_cnt_1", 192'(done_cnt), 192'd1);

    // Write and a second start mid-frame: frame unchanged, start dropped.
    expq.push_back(f1);
    go(s);
    tick(400);
    wr(4'd0, 8'hFF);
    start = 1'b1; tick(1); start = 1'b0;
    wait_done(4000);
    chk_timing(s);
    tick(500);
    chk("no_queued_frame", 192'(rises), 192'd192);
    chk("done_cnt_2", 192'(done_cnt), 192'd2);

    f2 = frame(32'h1234_56FF, 16'h00D2, 16'h00C8, 8'h01, 8'hA1, 8'hA2, 8'hA3);
    expq.push_back(f2);
    go(s);
    wait_done(4000);
    chk("q_empty_3", 192'(expq.size()), 192'd0);

    // Write and start in the same cycle: snapshot keeps the old state byte.
    address = 4'd8; write_data = 8'h55; write_en = 1'b1;
    expq.push_back(f2);
    go(s);
    write_en = 1'b0;
    wait_done(4000);
    expq.push_back(frame(32'h1234_56FF, 16'h00D2, 16'h00C8, 8'h55, 8'hA1, 8'hA2, 8'hA3));
    go(s);
    wait_done(4000);
    chk("q_empty_4", 192'(expq.size()), 192'd0);

    // Reset at bit 100 aborts the frame with no done.
    expq.push_back(f2);
    go(s);
    n = 0;
    while (bits < 100 && n < 2000) begin tick(1); n++; end
    chk("reach_bit100", 192'(bits), 192'd100);
    reset = 1'b1;
    d0 = done_cnt;
    tick(1);
    chk("abort_sclk", 192'(serial_clock), 192'd0);
    chk("abort_sd",   192'(serial_data),  192'd0);
    chk("abort_busy", 192'(busy),         192'd0);
    chk("abort_done", 192'(done),         192'd0);
    expq.delete();
    tick(2);
    reset = 1'b0;
    tick(50);
    chk("no_done_after_abort", 192'(done_cnt), 192'(d0));
    // Field registers were cleared by reset.
    expq.push_back(frame(32'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0));
    go(s);
    wait_done(4000);
    chk_timing(s);
    chk("q_empty_5", 192'(expq.size()), 192'd0);

`ifdef FRAME_REPEAT_EN
    wr(4'd9, 8'h3C);
    repeat_count = 4'd2;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++)
      expq.push_back(frame(32'h0, 16'h0, 16'h0, 8'h0, 8'h3C, 8'h0, 8'h0));
    go(s);
    repeat_count = 4'd0;
    wait_done(8000);
    chk("repeat_rises",   192'(rises),          192'd576);
    chk("repeat_one_done", 192'(done_cnt - d0), 192'd1);
    chk("repeat_done_cycle", 192'(done_cyc), 192'(s + 1 + 3 * (384 * CD + G)));
    chk("q_empty_rep", 192'(expq.size()), 192'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_encode.md
Name: serial_encode

Overview:
- Transmit-side counterpart of the BEP thermostat frame decoder. It generates bench/loopback stimulus and lets the chip act as a thermostat emulator.
- A host writes frame fields byte-wise over an address/data port, then pulses start. The block serialises one 192-bit frame onto serial_clock/serial_data, MSB first, in the same field order the decoder expects.
- Sits beside data_multiplex; its outputs can drive the decoder's serial inputs directly.

Parameters:
- CLK_DIV, 4, system clocks per serial_clock half-period (≥1).
- GAP_CYCLES, 16, idle system clocks after the last bit before done (≥1).
- PREAMBLE, 32'hAAAA_AAAA, fixed preamble field.
- TYPE_1, 16'h0000, fixed type_1 field.
- TYPE_2, 16'h0000, fixed type_2 field.
- CONSTANT, 32'h0000_0000, fixed constant field.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  4  field byte select, same map as the decoder (0-3 thermostat_id LSB→MSB, 4-5 room_temp, 6-7 set_temp, 8 state, 9-11 tail_1..tail_3).
- write_data  in  8  byte to store.
- write_en  in  1  store write_data at address this cycle.
- start  in  1  one-cycle request to send a frame.
- serial_clock  out  1  generated bit clock; idle low.
- serial_data  out  1  frame bit; valid on the rising edge of serial_clock.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset:
  - All field registers = 0. State = IDLE.
  - serial_clock = 0, serial_data = 0, busy = 0, done = 0.
  - Reset mid-frame aborts the frame immediately; no done pulse is issued.
- Field registers:
  - A write takes effect on the next edge and is legal at any time.
  - Addresses 12-15 are ignored.
  - Writes during a frame do not affect the frame in flight. The frame is snapshotted at start; writes apply to the next frame.
- Frame order, MSB first, 192 bits total: PREAMBLE(32), TYPE_1(16), TYPE_2(16), CONSTANT(32), thermostat_id(32), room_temp(16), set_temp(16), state(8), tail_1(8), tail_2(8), tail_3(8).
- FSM states: IDLE, SHIFT, GAP.
  - IDLE:
    - start=1 loads the 192-bit shift register and bit counter = 191, and enters SHIFT.
    - If write_en and start occur in the same cycle, the snapshot uses the pre-write value.
  - SHIFT:
    - The current MSB drives serial_data.
    - serial_clock is low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - On the final high cycle, shift left and decrement the counter.
    - After bit 0's high phase, serial_clock returns low, serial_data goes to 0, and the FSM enters GAP.
  - GAP: count GAP_CYCLES cycles, then pulse done for one cycle and return to IDLE. busy falls in the same cycle done pulses.
- Timing:
  - start accepted at cycle N → busy=1 and serial_data = bit 191 at N+1.
  - First rising serial_clock at N+1+CLK_DIV.
  - done at N+1+384·CLK_DIV+GAP_CYCLES.
- start while busy is ignored and not queued.
- serial_data changes only while serial_clock is low, so it is stable across every rising edge.

Optional Feature:
- Macro: FRAME_REPEAT_EN.
- Defined:
  - Adds an input repeat_count [3:0], sampled at start.
  - The frame is resent repeat_count+1 times, each separated by GAP_CYCLES, using the same snapshot.
  - done pulses once, after the final repeat. busy stays high throughout.
- Undefined: no extra port; exactly one frame per start.

Decomposition:
- Package bep_pkg:
  - Field widths, FRAME_BITS=192.
  - Address constants ADDR_ID0..ADDR_TAIL3.
  - FSM state encoding.
  - Default PREAMBLE/TYPE/CONSTANT values.
- Sub-module serial_bit_timer: half-period counter. Inputs enable and CLK_DIV; outputs serial_clock level, a bit_end strobe, and a low_phase flag. The top module holds the registers, FSM and shift register.

Test Plan:
- Reset then idle 100 cycles → serial_clock=0, serial_data=0, busy=0, done never pulses.
- Write id=32'h1234_5678, room=16'h00D2, set=16'h00C8, state=8'h01, tails=8'hA1/A2/A3; start; feed serial outputs into data_multiplex → its reads return identical bytes and its valid asserts.
- CLK_DIV=4, GAP_CYCLES=16: start at cycle 10 → busy rises at 11, first rising serial_clock at 15, done at 1563, exactly 192 rising edges.
- Mid-frame, write address 0 = 8'hFF and pulse start → current frame unchanged, no second frame; next start sends id byte0 = FF.
- Assert reset at bit 100 → outputs 0 next cycle, no done pulse; a new start sends a full 192-bit frame.
- FRAME_REPEAT_EN with repeat_count=2 → three identical frames, each followed by a 16-cycle gap, a single done, and 576 rising edges total.
